// File: rtl/fp_result_pack_if.sv
// -----------------------------------------------------------------------------
// fp_result_pack_if
//
// Purpose : Bundles the upstream operand handshake and the downstream result
//           handshake of the FP multiply/divide result packer.
//
// Modports:
//   master - the side that produces operands and consumes results (the
//            surrounding datapath, or a testbench).
//   slave  - the packer itself.
//
// Signals:
//   in_valid / in_ready           upstream valid/ready handshake
//   in_sign                       result sign (sA ^ sB)
//   in_e[EW-1:0]                  signed biased intermediate exponent
//   in_mant[MW-1:0]               unnormalized significand in [1,4)
//   in_nan / in_inf / in_zero     upstream-resolved special-case flags
//   out_valid / out_ready         downstream valid/ready handshake
//   out_result[31:0]              packed IEEE-754 single
//   out_ovf / out_unf             range exception of this result
//   out_inexact                   rounding discarded nonzero bits
// -----------------------------------------------------------------------------
interface fp_result_pack_if #(
  parameter int MW = 48,
  parameter int EW = 10
);

  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_e;
  logic [MW-1:0] in_mant;
  logic          in_nan;
  logic          in_inf;
  logic          in_zero;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_ovf;
  logic          out_unf;
  logic          out_inexact;

  modport master (
    output in_valid, in_sign, in_e, in_mant, in_nan, in_inf, in_zero,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_e, in_mant, in_nan, in_inf, in_zero,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_ovf, out_unf, out_inexact
  );

endinterface : fp_result_pack_if

// File: rtl/fp_result_pack.sv
// -----------------------------------------------------------------------------
// fp_result_pack
//
// Purpose : Back end of the FP multiply/divide datapath. Normalizes the raw
//           significand product/quotient, rounds to nearest-even, checks the
//           exponent range (flush-to-zero, no subnormals) and packs an
//           IEEE-754 single-precision result. Special cases from upstream
//           (NaN > Inf > Zero) override the arithmetic result.
//
//           Two register stages:
//             stage 1 - normalize: pick frac/guard/sticky, adjust exponent
//             stage 2 - round, range check, pack into the output register
//           Both stages advance together whenever the output register is
//           empty or being drained, giving 1 result/cycle and a 2-cycle
//           latency from an accepted input to out_valid.
//
// Parameters:
//   MW - significand width; value in [1,4), binary point between MW-2, MW-3
//   EW - intermediate exponent width, signed two's complement, biased
//
// Ports:
//   clk      rising-edge clock
//   arst     asynchronous active-high reset
//   en       global enable; when low every register holds and in_ready=0
//   bus      fp_result_pack_if.slave: upstream and downstream handshakes
//
// Optional feature (macro FLAGS_STICKY_EN):
//   flag_clr         clears the sticky flags (clear wins over set)
//   sticky_ovf       set by any completed output transfer flagged ovf
//   sticky_unf       set by any completed output transfer flagged unf
//   sticky_inexact   set by any completed output transfer flagged inexact
// -----------------------------------------------------------------------------
module fp_result_pack #(
  parameter int MW = 48,
  parameter int EW = 10
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  fp_result_pack_if.slave   bus
`ifdef FLAGS_STICKY_EN
  ,
  input  logic              flag_clr,
  output logic              sticky_ovf,
  output logic              sticky_unf,
  output logic              sticky_inexact
`endif
);

  localparam int FW = 23;  // stored fraction width of a single

  // Exponent thresholds, held at the stage exponent width so the range
  // comparisons below stay signed.
  localparam logic signed [EW:0] E_MAX  = (EW+1)'(255);
  localparam logic signed [EW:0] E_ZERO = '0;
  localparam logic signed [EW:0] E_ONE  = (EW+1)'(1);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;
  logic adv;

  // The whole pipe moves as one; the output register is the only place a
  // stall can originate, so no per-stage ready chain is needed.
  assign adv          = en & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: normalize
  // ---------------------------------------------------------------------------
  logic                 n1_hi;
  logic [FW-1:0]        n1_frac;
  logic                 n1_g;
  logic                 n1_s;
  logic signed [EW:0]   n1_e_ext;
  logic signed [EW:0]   n1_e;

  assign n1_hi = bus.in_mant[MW-1];

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here by assigning defaults first); a path that leaves one unassigned
  // makes synthesis infer a latch to remember the old value.
  always_comb begin
    n1_frac  = bus.in_mant[MW-3 -: FW];
    n1_g     = bus.in_mant[MW-26];
    n1_s     = |bus.in_mant[MW-27:0];
    n1_e_ext = {bus.in_e[EW-1], bus.in_e};
    n1_e     = n1_e_ext;
    if (n1_hi) begin
      // Significand in [2,4): shift the window up one bit and bump the
      // exponent. The bit that drops out of the window joins the sticky OR.
      n1_frac = bus.in_mant[MW-2 -: FW];
      n1_g    = bus.in_mant[MW-25];
      n1_s    = |bus.in_mant[MW-26:0];
      n1_e    = n1_e_ext + E_ONE;
    end
  end

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q,  s1_sign_d;
  logic [FW-1:0]        s1_frac_q,  s1_frac_d;
  logic                 s1_g_q,     s1_g_d;
  logic                 s1_s_q,     s1_s_d;
  logic signed [EW:0]   s1_e_q,     s1_e_d;
  logic                 s1_nan_q,   s1_nan_d;
  logic                 s1_inf_q,   s1_inf_d;
  logic                 s1_zero_q,  s1_zero_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_frac_d  = s1_frac_q;
    s1_g_d     = s1_g_q;
    s1_s_d     = s1_s_q;
    s1_e_d     = s1_e_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    s1_zero_d  = s1_zero_q;
    if (adv) begin
      s1_valid_d = bus.in_valid;
    end
    // Data only loads on a real transfer; a bubble leaves it stale, which is
    // harmless because the valid bit travels with it.
    if (adv && bus.in_valid) begin
      s1_sign_d = bus.in_sign;
      s1_frac_d = n1_frac;
      s1_g_d    = n1_g;
      s1_s_d    = n1_s;
      s1_e_d    = n1_e;
      s1_nan_d  = bus.in_nan;
      s1_inf_d  = bus.in_inf;
      s1_zero_d = bus.in_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: round to nearest-even, range check, pack
  // ---------------------------------------------------------------------------
  logic                 r2_up;
  logic [FW+1:0]        r2_sig;
  logic [FW-1:0]        r2_frac;
  logic signed [EW:0]   r2_e;
  logic                 r2_inexact;
  logic [31:0]          r2_result;
  logic                 r2_ovf;
  logic                 r2_unf;
  logic                 r2_inx_out;

  always_comb begin
    r2_up      = s1_g_q & (s1_s_q | s1_frac_q[0]);
    r2_sig     = {2'b01, s1_frac_q} + {{(FW+1){1'b0}}, r2_up};
    r2_frac    = r2_sig[FW-1:0];
    r2_e       = s1_e_q;
    r2_inexact = s1_g_q | s1_s_q;
    if (r2_sig[FW+1]) begin
      // Rounding carried out of 1.111..1: the significand becomes 10.000..0,
      // i.e. 1.0 with the exponent one higher.
      r2_frac = '0;
      r2_e    = s1_e_q + E_ONE;
    end

    r2_result  = {s1_sign_q, r2_e[7:0], r2_frac};
    r2_ovf     = 1'b0;
    r2_unf     = 1'b0;
    r2_inx_out = r2_inexact;

    if (s1_nan_q) begin
      r2_result  = QNAN;
      r2_inx_out = 1'b0;
    end else if (s1_inf_q) begin
      r2_result  = {s1_sign_q, 8'hFF, {FW{1'b0}}};
      r2_inx_out = 1'b0;
    end else if (s1_zero_q) begin
      r2_result  = {s1_sign_q, 31'h0};
      r2_inx_out = 1'b0;
    end else if (r2_e >= E_MAX) begin
      r2_result  = {s1_sign_q, 8'hFF, {FW{1'b0}}};
      r2_ovf     = 1'b1;
      r2_inx_out = 1'b1;
    end else if (r2_e <= E_ZERO) begin
      // No subnormal support: anything below the normal range flushes.
      r2_result  = {s1_sign_q, 31'h0};
      r2_unf     = 1'b1;
      r2_inx_out = 1'b1;
    end
  end

  logic [31:0] out_result_q,  out_result_d;
  logic        out_ovf_q,     out_ovf_d;
  logic        out_unf_q,     out_unf_d;
  logic        out_inexact_q, out_inexact_d;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_ovf_d     = out_ovf_q;
    out_unf_d     = out_unf_q;
    out_inexact_d = out_inexact_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
    end
    if (adv && s1_valid_q) begin
      out_result_d  = r2_result;
      out_ovf_d     = r2_ovf;
      out_unf_d     = r2_unf;
      out_inexact_d = r2_inx_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_ovf_q     <= 1'b0;
      out_unf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_ovf_q     <= out_ovf_d;
      out_unf_q     <= out_unf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  // NOTE: stage-1 data registers are deliberately left without reset; they
  // are only ever observed behind s1_valid_q, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    s1_sign_q <= s1_sign_d;
    s1_frac_q <= s1_frac_d;
    s1_g_q    <= s1_g_d;
    s1_s_q    <= s1_s_d;
    s1_e_q    <= s1_e_d;
    s1_nan_q  <= s1_nan_d;
    s1_inf_q  <= s1_inf_d;
    s1_zero_q <= s1_zero_d;
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_unf     = out_unf_q;
  assign bus.out_inexact = out_inexact_q;

`ifdef FLAGS_STICKY_EN
  // ---------------------------------------------------------------------------
  // Sticky exception flags
  // ---------------------------------------------------------------------------
  logic out_xfer;
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_unf_q, sticky_unf_d;
  logic sticky_inx_q, sticky_inx_d;

  // Only results that actually leave the block count; a held result under
  // backpressure or en=0 must not set anything.
  assign out_xfer = en & out_valid_q & bus.out_ready;

  always_comb begin
    sticky_ovf_d = sticky_ovf_q | (out_xfer & out_ovf_q);
    sticky_unf_d = sticky_unf_q | (out_xfer & out_unf_q);
    sticky_inx_d = sticky_inx_q | (out_xfer & out_inexact_q);
    if (flag_clr) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
      sticky_inx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      sticky_inx_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      sticky_inx_q <= sticky_inx_d;
    end
  end

  assign sticky_ovf     = sticky_ovf_q;
  assign sticky_unf     = sticky_unf_q;
  assign sticky_inexact = sticky_inx_q;
`endif

endmodule : fp_result_pack

// File: tb/tb_fp_result_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_result_pack
//
// Directed, table-driven bench for fp_result_pack. Each vector carries the
// operand fields and the hand-computed packed result and flags
// ({ovf, unf, inexact}). Inputs are driven 1 time unit after the rising edge;
// outputs are sampled either 1 unit after the edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_fp_result_pack;

  localparam int MW = 48;
  localparam int EW = 10;
  localparam int NV = 18;

  typedef struct {
    logic          sign;
    logic [EW-1:0] e;
    logic [MW-1:0] mant;
    logic          nan;
    logic          inf;
    logic          zero;
    logic [31:0]   res;
    logic [2:0]    flags;  // {ovf, unf, inexact}
  } vec_t;

  logic clk = 1'b0;
  logic arst;
  logic en;

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_xfer   = 0;
  bit   mon_en   = 1'b0;
  int   cur_idx  = 0;
  int   m_idx;
  int   exp_q[$];
  vec_t vecs[NV];

  fp_result_pack_if #(.MW(MW), .EW(EW)) bus ();

  fp_result_pack #(.MW(MW), .EW(EW)) dut (
    .clk  (clk),
    .arst (arst),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int idx);
    cur_idx      = idx;
    bus.in_valid = 1'b1;
    bus.in_sign  = vecs[idx].sign;
    bus.in_e     = vecs[idx].e;
    bus.in_mant  = vecs[idx].mant;
    bus.in_nan   = vecs[idx].nan;
    bus.in_inf   = vecs[idx].inf;
    bus.in_zero  = vecs[idx].zero;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_e     = '0;
    bus.in_mant  = '0;
    bus.in_nan   = 1'b0;
    bus.in_inf   = 1'b0;
    bus.in_zero  = 1'b0;
  endtask

  // Single vector through an otherwise empty pipe; call at posedge+1.
  task automatic apply_vec(input int i);
    int lat;
    bit got;
    drive(i);
    @(posedge clk); #1;
    idle();
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) got = 1'b1;
    end
    if (!got) begin
      check($sformatf("v%0d.timeout", i), bus.out_valid, 1);
    end else begin
      check($sformatf("v%0d.latency", i), lat, 2);
      check($sformatf("v%0d.result", i), bus.out_result, vecs[i].res);
      check($sformatf("v%0d.flags", i), {bus.out_ovf, bus.out_unf, bus.out_inexact}, vecs[i].flags);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d.bubble", i), bus.out_valid, 0);
  endtask

  // Streams n vectors back to back; during [stall_at, stall_at+stall_len)
  // either out_ready or en is held low. Call at posedge+1.
  task automatic run_stream(input int first, input int n, input int stall_at,
                            input int stall_len, input bit use_en);
    int          i;
    int          cyc;
    int          x0;
    bit          stall;
    logic [31:0] held;
    i    = 0;
    cyc  = 0;
    x0   = n_xfer;
    held = '0;
    while ((i < n || exp_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      stall         = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      en            = !(stall && use_en);
      bus.out_ready = !(stall && !use_en);
      if (i < n) drive(first + i);
      else       idle();
      @(negedge clk);
      if (stall) begin
        check("stall.in_ready", bus.in_ready, 0);
        check("stall.out_valid", bus.out_valid, 1);
        if (cyc == stall_at) held = bus.out_result;
        else                 check("stall.hold", bus.out_result, held);
      end
      if (bus.in_valid && bus.in_ready) i++;
      @(posedge clk); #1;
      cyc++;
    end
    en            = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    check("stream.accepted", i, n);
    check("stream.xfers", n_xfer - x0, n);
    check("stream.drained", exp_q.size(), 0);
  endtask

  // Scoreboard for streaming tests: inputs are recorded on acceptance and
  // matched in order against completed output transfers.
  always @(negedge clk) begin
    if (mon_en && !arst) begin
      if (en && bus.out_valid && bus.out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("mon.unexpected", bus.out_valid, 0);
        end else begin
          m_idx = exp_q.pop_front();
          check($sformatf("mon.v%0d.result", m_idx), bus.out_result, vecs[m_idx].res);
          check($sformatf("mon.v%0d.flags", m_idx),
                {bus.out_ovf, bus.out_unf, bus.out_inexact}, vecs[m_idx].flags);
        end
      end
      if (en && bus.in_valid && bus.in_ready) exp_q.push_back(cur_idx);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int valid_seen;

    //            sign  e        mant                nan   inf   zero  result         {ovf,unf,inx}
    vecs[0]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000}; // 1.5*1.5
    vecs[1]  = '{1'b0, 10'd127, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001}; // round carry
    vecs[2]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001}; // tie, even stays
    vecs[3]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001}; // tie, odd rounds up
    vecs[4]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101}; // overflow
    vecs[5]  = '{1'b1, 10'd0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011}; // underflow
    vecs[6]  = '{1'b0, 10'd127, 48'h9000_0000_0000, 1'b1, 1'b1, 1'b0, 32'h7FC0_0000, 3'b000}; // nan beats inf
    vecs[7]  = '{1'b1, 10'd127, 48'h9000_0000_0000, 1'b0, 1'b1, 1'b0, 32'hFF80_0000, 3'b000}; // -inf
    vecs[8]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'b000}; // zero beats ovf
    vecs[9]  = '{1'b0, 10'd0,   48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b001}; // carry lifts to min normal
    vecs[10] = '{1'b0, 10'd254, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101}; // carry into overflow
    vecs[11] = '{1'b0, 10'd253, 48'h8000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 3'b000}; // max exponent 254
    vecs[12] = '{1'b1, 10'h3FB, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011}; // negative exponent
    vecs[13] = '{1'b0, 10'd127, 48'h4000_0000_0001, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001}; // sticky only
    vecs[14] = '{1'b1, 10'd126, 48'hC000_0000_0000, 1'b0, 1'b0, 1'b0, 32'hBFC0_0000, 3'b000}; // -1.5
    vecs[15] = '{1'b1, 10'd127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 3'b000}; // -0
    vecs[16] = '{1'b0, 10'd1,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 3'b000}; // min normal
    vecs[17] = '{1'b0, 10'd127, 48'h4000_0060_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 3'b001}; // above half

    // Reset state
    arst          = 1'b1;
    en            = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.out_result", bus.out_result, 0);
    check("rst.flags", {bus.out_ovf, bus.out_unf, bus.out_inexact}, 0);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    check("rst.in_ready", bus.in_ready, 1);

    // One vector at a time: latency, value, flags, bubble
    for (int i = 0; i < NV; i++) apply_vec(i);

    // Full-throughput stream, then backpressure via out_ready and via en
    mon_en = 1'b1;
    run_stream(0, NV, -10, 0, 1'b0);
    run_stream(0, 4, 2, 3, 1'b0);
    run_stream(4, 4, 2, 3, 1'b1);
    mon_en = 1'b0;

    // Reset in the middle of a stream
    drive(0);
    @(posedge clk); #1;
    drive(1);
    @(posedge clk); #1;
    drive(2);
    check("rst_mid.pre_valid", bus.out_valid, 1);
    #3;
    arst = 1'b1;
    #1;
    check("rst_mid.out_valid", bus.out_valid, 0);
    check("rst_mid.out_result", bus.out_result, 0);
    check("rst_mid.flags", {bus.out_ovf, bus.out_unf, bus.out_inexact}, 0);
    idle();
    @(negedge clk);
    arst = 1'b0;
    valid_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) valid_seen++;
    end
    check("rst_mid.no_stale", valid_seen, 0);
    apply_vec(14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_fp_result_pack

// File: doc/fp_result_pack.md
Name: fp_result_pack

Overview:
Back end of the FP multiply/divide datapath. It consumes the signed intermediate exponent produced by the exponent adder, the raw significand product or quotient, and the special-case flags. It normalizes, rounds to nearest-even, checks exponent range and packs an IEEE-754 single-precision result. Two-stage pipeline with valid/ready handshake toward both the upstream datapath and the downstream consumer.

Parameters:
MW, 48, significand input width; value in [1,4), binary point between bit MW-2 and MW-3
EW, 10, intermediate exponent width, signed two's complement, bias 127 already applied

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous active-high reset
en  input  1  global enable; when 0, all pipeline registers hold, in_ready=0
in_valid  input  1  upstream operand valid
in_ready  output  1  block can accept this cycle
in_sign  input  1  result sign (sA ^ sB)
in_e  input  EW  signed biased intermediate exponent
in_mant  input  MW  unnormalized significand
in_nan  input  1  result is NaN (upstream-resolved)
in_inf  input  1  result is infinity
in_zero  input  1  result is zero
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_result  output  32  packed IEEE-754 single
out_ovf  output  1  overflow on this result
out_unf  output  1  underflow (flushed) on this result
out_inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset: all stage valids=0, out_valid=0, out_result=0, out_ovf=out_unf=out_inexact=0.
- Advance condition: adv = en & (~out_valid | out_ready); in_ready = adv. Both stages move together on adv; a transfer happens when in_valid & in_ready.
- Latency: 2 cycles from accepted input to out_valid at full throughput (1 result/cycle). out_* stay stable while out_valid & ~out_ready.
- Stage 1 (normalize): if in_mant[MW-1]=1: frac=in_mant[MW-2:MW-24], G=in_mant[MW-25], S=OR(in_mant[MW-26:0]), e1=in_e+1. Else frac=in_mant[MW-3:MW-25], G=in_mant[MW-26], S=OR(in_mant[MW-27:0]), e1=in_e. e1 is kept EW+1 bits signed so no wrap.
- Stage 2 (round/pack): up = G & (S | frac[0]). sig = {1,frac}+up (25 bits). If sig carry: frac_r=0, e2=e1+1; else frac_r=sig[22:0], e2=e1. inexact = G|S.
- Range: e2 >= 255 -> {sign,8'hFF,23'h0}, ovf=1, inexact=1. e2 <= 0 -> {sign,31'h0}, unf=1, inexact=1 (flush-to-zero, no subnormals). Else {sign,e2[7:0],frac_r}.
- Specials override arithmetic, priority nan > inf > zero: nan -> 32'h7FC00000; inf -> {sign,8'hFF,23'h0}; zero -> {sign,31'h0}; all flags 0 for specials.
- Bubble (stage valid=0) propagates with out_valid=0; data registers may hold stale values.
- arst mid-operation: in-flight results discarded, outputs return to reset values immediately.
- en=0 with out_valid=1: output held, out_ready ignored (no handshake completes).

Optional Feature:
FLAGS_STICKY_EN: when defined, adds input flag_clr (1) and outputs sticky_ovf, sticky_unf, sticky_inexact (1 each). Each sticky bit sets on a completed output transfer (out_valid & out_ready & en) carrying that flag, and clears when flag_clr=1 (clear wins over set in the same cycle); reset value 0. When undefined, these ports and registers do not exist and per-result flags are the only exception report.

Test Plan:
- 1.5*1.5: in_e=127, in_mant=0x900000000000, sign=0 -> after 2 cycles out_result=0x40100000, flags 0.
- Round carry: in_e=127, in_mant=0x7FFFFFFFFFFF -> 0x40000000, inexact=1.
- Ties-to-even: in_e=127, in_mant=0x400000400000 -> 0x3F800000, inexact=1; in_mant=0x400000C00000 -> 0x3F800002, inexact=1.
- Range: in_e=254, in_mant=0x800000000000 -> 0x7F800000, ovf=1; in_e=0, in_mant=0x400000000000, sign=1 -> 0x80000000, unf=1.
- Specials: in_nan=1 & in_inf=1 -> 0x7FC00000; in_inf=1, sign=1 -> 0xFF800000; in_zero=1 -> 0x00000000; flags 0.
- Backpressure/reset: stream 4 back-to-back inputs, hold out_ready=0 for 3 cycles -> in_ready=0, out_result stable, no loss or duplication after release; assert arst mid-stream -> out_valid=0 same cycle, no stale result emitted afterwards.
